// File: rtl/memport_pkg.sv
// Shared types and helpers for the single-port memory arbiter.
package memport_pkg;

    localparam int unsigned RAM_AW_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE,
        D_RESP,
        F_RESP
    } memport_state_t;

    typedef struct packed {
        logic        err;
        logic [31:0] idx;
    } addr_chk_t;

    // Word index of a byte address plus a flag for misaligned or out-of-range addresses.
    function automatic addr_chk_t word_index_chk(input logic [31:0] addr, input int unsigned aw);
        addr_chk_t   r;
        logic [31:0] mask;
        mask  = (32'd1 << aw) - 32'd1;
        r.idx = (addr >> 2) & mask;
        r.err = (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
        return r;
    endfunction

endpackage

// File: rtl/memport_addr_chk.sv
// Combinational byte-address to RAM word-index conversion with range/alignment check.
module memport_addr_chk
    import memport_pkg::*;
#(
    parameter int unsigned RAM_AW = RAM_AW_DEFAULT
) (
    input  logic [31:0]       byte_addr,
    output logic [RAM_AW-1:0] word_idx,
    output logic              addr_err
);

    addr_chk_t chk;

    // Truncated word index and error flag for the address being issued.
    always_comb begin
        chk      = word_index_chk(byte_addr, RAM_AW);
        word_idx = RAM_AW'(chk.idx);
        addr_err = chk.err;
    end

endmodule

// File: rtl/memport_arbiter.sv
// Arbitrates fetch and MEM-stage accesses onto one synchronous-read RAM port.
module memport_arbiter
    import memport_pkg::*;
#(
    parameter int unsigned RAM_AW = RAM_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ready,
    output logic [31:0]       if_instr,
    input  logic              regmem_M,
    input  logic              memw_M,
    input  logic [31:0]       address_M,
    input  logic [31:0]       wdata_M,
    output logic              m_ready,
    output logic [31:0]       m_rdata,
    output logic              stall_F,
    output logic              stall_M,
    output logic              err_addr,
    output logic [RAM_AW-1:0] ram_address,
    output logic [31:0]       ram_data,
    output logic              ram_wren,
    input  logic [31:0]       ram_q
);

    memport_state_t    state;
    memport_state_t    state_nx;
    logic              is_store_q;
    logic              dreq;
    logic              issue_d;
    logic              issue_f;
    logic [31:0]       issue_addr;
    logic [RAM_AW-1:0] issue_idx;
    logic              issue_err;

    memport_addr_chk #(.RAM_AW(RAM_AW)) u_addr_chk (
        .byte_addr (issue_addr),
        .word_idx  (issue_idx),
        .addr_err  (issue_err)
    );

    // State register, latched access type and sticky address error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            is_store_q <= 1'b0;
            err_addr   <= 1'b0;
        end else begin
            state <= state_nx;
            if (issue_d) begin
                is_store_q <= memw_M;
            end
            if ((issue_d | issue_f) & issue_err) begin
                err_addr <= 1'b1;
            end
        end
    end

    // Next state, issue decisions and ready strobes; reset suppresses all of them.
    always_comb begin
        state_nx = state;
        issue_d  = 1'b0;
        issue_f  = 1'b0;
        if_ready = 1'b0;
        m_ready  = 1'b0;
        dreq     = regmem_M | memw_M;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (dreq) begin
                        issue_d  = 1'b1;
                        state_nx = D_RESP;
                    end else if (if_req) begin
                        issue_f  = 1'b1;
                        state_nx = F_RESP;
                    end
                end
                D_RESP: begin
                    m_ready = 1'b1;
                    if (if_req) begin
                        issue_f  = 1'b1;
                        state_nx = F_RESP;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                F_RESP: begin
                    if_ready = 1'b1;
                    if (dreq) begin
                        issue_d  = 1'b1;
                        state_nx = D_RESP;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // RAM port drive, response data muxes and pipeline stalls.
    always_comb begin
        issue_addr  = issue_d ? address_M : (issue_f ? if_addr : '0);
        ram_address = (issue_d | issue_f) ? issue_idx : '0;
        ram_wren    = issue_d & memw_M;
        ram_data    = (issue_d & memw_M) ? wdata_M : '0;
        if_instr    = if_ready ? ram_q : '0;
        m_rdata     = (m_ready & ~is_store_q) ? ram_q : '0;
        stall_F     = if_req & ~if_ready;
        stall_M     = (regmem_M | memw_M) & ~m_ready;
    end

endmodule

// File: tb/tb_memport_arbiter.sv
// Self-checking bench: directed scenarios, then randomized traffic scored against a memory model.
module tb_memport_arbiter;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [31:0]   if_addr = '0;
    logic          if_ready;
    logic [31:0]   if_instr;
    logic          regmem_M = 1'b0;
    logic          memw_M = 1'b0;
    logic [31:0]   address_M = '0;
    logic [31:0]   wdata_M = '0;
    logic          m_ready;
    logic [31:0]   m_rdata;
    logic          stall_F;
    logic          stall_M;
    logic          err_addr;
    logic [AW-1:0] ram_address;
    logic [31:0]   ram_data;
    logic          ram_wren;
    logic [31:0]   ram_q;

    always #5 clk = ~clk;

    memport_arbiter #(.RAM_AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .regmem_M    (regmem_M),
        .memw_M      (memw_M),
        .address_M   (address_M),
        .wdata_M     (wdata_M),
        .m_ready     (m_ready),
        .m_rdata     (m_rdata),
        .stall_F     (stall_F),
        .stall_M     (stall_M),
        .err_addr    (err_addr),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    // Synchronous-read RAM attached to the arbiter.
    logic [31:0] ram     [0:1023];
    // Reference contents, updated from the requesters' point of view.
    logic [31:0] ref_mem [0:1023];

    always @(posedge clk) begin
        if (ram_wren) ram[ram_address] <= ram_data;
        ram_q <= ram[ram_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t f_q[$];
    exp_t d_q[$];
    bit   chk_on = 1'b0;
    int   err_cyc = 32'h3FFF_FFFF;
    logic f_seen;
    logic d_seen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit ref_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd4096);
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        return int'((a / 4) % 1024);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Remember which requester completed this cycle so the driver can retire it.
    always @(negedge clk) begin
        f_seen <= if_ready;
        d_seen <= m_ready;
    end

    // Monitor: pop the expected response whenever the DUT presents one.
    always @(negedge clk) begin
        exp_t e;
        if (chk_on) begin
            chk("stall_F", {31'd0, stall_F},
                {31'd0, if_req && !(f_q.size() > 0 && f_q[0].due == cyc)});
            chk("stall_M", {31'd0, stall_M},
                {31'd0, (regmem_M || memw_M) && !(d_q.size() > 0 && d_q[0].due == cyc)});
            chk("err_addr", {31'd0, err_addr}, {31'd0, cyc >= err_cyc});
            if (if_ready) begin
                if (f_q.size() == 0) begin
                    chk("if_ready_spurious", {31'd0, if_ready}, 32'd0);
                end else begin
                    e = f_q.pop_front();
                    chk("if_ready_cycle", cyc, e.due);
                    chk("if_instr", if_instr, e.data);
                end
            end else if (f_q.size() > 0 && cyc >= f_q[0].due) begin
                chk("if_ready_missing", {31'd0, if_ready}, 32'd1);
                void'(f_q.pop_front());
            end
            if (m_ready) begin
                if (d_q.size() == 0) begin
                    chk("m_ready_spurious", {31'd0, m_ready}, 32'd0);
                end else begin
                    e = d_q.pop_front();
                    chk("m_ready_cycle", cyc, e.due);
                    chk("m_rdata", m_rdata, e.data);
                end
            end else if (d_q.size() > 0 && cyc >= d_q[0].due) begin
                chk("m_ready_missing", {31'd0, m_ready}, 32'd1);
                void'(d_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        int          idx;
        int          k;
        int          due;
        bit          f_pend;
        bit          d_pend;
        bit          d_started;

        for (int i = 0; i < 1024; i++) begin
            ram[i]     = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
            ref_mem[i] = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
        end
        ram[4]     = 32'hE3A01005;
        ref_mem[4] = 32'hE3A01005;

        // Reset held with requests pending.
        rst = 1'b1; if_req = 1'b1; memw_M = 1'b1; if_addr = 32'h10;
        address_M = 32'h800; wdata_M = 32'hA5A50001;
        for (int r = 0; r < 2; r++) begin
            tick();
            chk("rst_wren", {31'd0, ram_wren}, 32'd0);
            chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
            chk("rst_m_ready", {31'd0, m_ready}, 32'd0);
            chk("rst_err", {31'd0, err_addr}, 32'd0);
            chk("rst_addr", {22'd0, ram_address}, 32'd0);
        end
        tick(); rst = 1'b0; #1;
        chk("post_rst_wren", {31'd0, ram_wren}, 32'd1);
        chk("post_rst_addr", {22'd0, ram_address}, 32'd512);
        chk("post_rst_data", ram_data, 32'hA5A50001);
        ref_mem[512] = 32'hA5A50001;
        tick();
        chk("post_rst_m_ready", {31'd0, m_ready}, 32'd1);
        chk("post_rst_fetch_addr", {22'd0, ram_address}, 32'd4);
        memw_M = 1'b0;
        tick();
        chk("post_rst_if_instr", if_instr, 32'hE3A01005);
        if_req = 1'b0;

        // Lone fetch.
        tick(); if_req = 1'b1; if_addr = 32'h10; #1;
        chk("fetch_addr", {22'd0, ram_address}, 32'd4);
        chk("fetch_stall_c0", {31'd0, stall_F}, 32'd1);
        tick();
        chk("fetch_ready", {31'd0, if_ready}, 32'd1);
        chk("fetch_instr", if_instr, 32'hE3A01005);
        chk("fetch_stall_c1", {31'd0, stall_F}, 32'd0);
        if_req = 1'b0;

        // Store then load at the same address.
        tick(); memw_M = 1'b1; address_M = 32'h20; wdata_M = 32'h0000FFFF; #1;
        chk("store_wren", {31'd0, ram_wren}, 32'd1);
        chk("store_addr", {22'd0, ram_address}, 32'd8);
        chk("store_stall", {31'd0, stall_M}, 32'd1);
        ref_mem[8] = 32'h0000FFFF;
        tick();
        chk("store_ready", {31'd0, m_ready}, 32'd1);
        chk("store_rdata", m_rdata, 32'd0);
        memw_M = 1'b0;
        tick(); regmem_M = 1'b1; #1;
        chk("load_wren", {31'd0, ram_wren}, 32'd0);
        tick();
        chk("load_rdata", m_rdata, 32'h0000FFFF);
        regmem_M = 1'b0;

        // Simultaneous fetch and load: data first.
        tick(); if_req = 1'b1; regmem_M = 1'b1; #1;
        chk("cont_c0_addr", {22'd0, ram_address}, 32'd8);
        chk("cont_c0_stall", {30'd0, stall_F, stall_M}, 32'd3);
        tick();
        chk("cont_c1_m_ready", {31'd0, m_ready}, 32'd1);
        chk("cont_c1_rdata", m_rdata, 32'h0000FFFF);
        chk("cont_c1_fetch_addr", {22'd0, ram_address}, 32'd4);
        chk("cont_c1_stall", {30'd0, stall_F, stall_M}, 32'd2);
        regmem_M = 1'b0;
        tick();
        chk("cont_c2_instr", if_instr, 32'hE3A01005);
        chk("cont_c2_stall", {31'd0, stall_F}, 32'd0);
        if_req = 1'b0;

        // Misaligned / out-of-range load, then a load+store that must act as a store.
        tick(); regmem_M = 1'b1; address_M = 32'h00010006; #1;
        chk("bad_addr_idx", {22'd0, ram_address}, 32'd1);
        chk("bad_err_c0", {31'd0, err_addr}, 32'd0);
        tick();
        chk("bad_rdata", m_rdata, ref_mem[1]);
        chk("bad_err_c1", {31'd0, err_addr}, 32'd1);
        regmem_M = 1'b0;
        tick();
        chk("bad_err_sticky", {31'd0, err_addr}, 32'd1);
        regmem_M = 1'b1; memw_M = 1'b1; address_M = 32'h30; wdata_M = 32'h12345678; #1;
        chk("both_wren", {31'd0, ram_wren}, 32'd1);
        chk("both_addr", {22'd0, ram_address}, 32'd12);
        ref_mem[12] = 32'h12345678;
        tick();
        chk("both_rdata", m_rdata, 32'd0);
        regmem_M = 1'b0; memw_M = 1'b0;
        tick(); regmem_M = 1'b1; #1;
        tick();
        chk("both_readback", m_rdata, 32'h12345678);
        chk("bad_err_still", {31'd0, err_addr}, 32'd1);
        regmem_M = 1'b0;

        // Reset during D_RESP with a fetch pending.
        tick(); if_req = 1'b1; regmem_M = 1'b1; address_M = 32'h20; #1;
        tick(); rst = 1'b1; #1;
        chk("midrst_m_ready", {31'd0, m_ready}, 32'd0);
        chk("midrst_rdata", m_rdata, 32'd0);
        chk("midrst_wren", {31'd0, ram_wren}, 32'd0);
        chk("midrst_addr", {22'd0, ram_address}, 32'd0);
        tick(); rst = 1'b0; if_req = 1'b0; regmem_M = 1'b0; #1;
        chk("midrst_idle_ready", {30'd0, if_ready, m_ready}, 32'd0);
        chk("midrst_err_clr", {31'd0, err_addr}, 32'd0);
        chk("midrst_idle_addr", {22'd0, ram_address}, 32'd0);
        tick();

        // Randomized traffic.
        err_cyc = 32'h3FFF_FFFF;
        f_pend  = 1'b0;
        d_pend  = 1'b0;
        chk_on  = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            tick();
            d_started = 1'b0;
            if (d_pend && d_seen) begin
                d_pend = 1'b0; regmem_M = 1'b0; memw_M = 1'b0;
            end
            if (f_pend && f_seen) begin
                f_pend = 1'b0; if_req = 1'b0;
            end
            if (!d_pend && n < 2980 && $urandom_range(0, 1) == 1) begin
                k = int'($urandom_range(0, 3));
                if (k < 2) begin
                    a = $urandom_range(0, 1023) * 4;
                    if ($urandom_range(0, 15) == 0) a = $urandom();
                    regmem_M = 1'b1;
                    wd = ref_mem[ref_idx(a)];
                end else begin
                    a = $urandom_range(256, 1023) * 4;
                    if ($urandom_range(0, 15) == 0) a = a + $urandom_range(1, 3);
                    wdata_M = $urandom();
                    ref_mem[ref_idx(a)] = wdata_M;
                    memw_M = 1'b1;
                    regmem_M = (k == 3);
                    wd = 32'd0;
                end
                address_M = a;
                d_q.push_back('{wd, cyc + 1});
                if (ref_bad(a) && cyc + 1 < err_cyc) err_cyc = cyc + 1;
                d_pend = 1'b1;
                d_started = 1'b1;
            end
            if (!f_pend && n < 2980 && $urandom_range(0, 2) != 0) begin
                a = $urandom_range(0, 255) * 4;
                if ($urandom_range(0, 15) == 0) a = a + $urandom_range(1, 3);
                if_addr = a;
                if_req = 1'b1;
                due = cyc + 1 + (d_started ? 1 : 0);
                f_q.push_back('{ref_mem[ref_idx(a)], due});
                if (ref_bad(a) && due < err_cyc) err_cyc = due;
                f_pend = 1'b1;
            end
        end
        chk_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memport_arbiter.md
# memport_arbiter

Single-port data/instruction memory arbiter between the fetch stage and the MEM stage. It sits on the outputs of the EX/MEM pipeline register. It serialises instruction fetches and MEM-stage loads/stores onto one synchronous-read RAM, and raises stall signals that hold the pipeline until each access completes. Data accesses take priority because they belong to the older instruction. Pending requests alternate so neither side starves.

## Interface
- `RAM_AW`, default 10: RAM word-address width; RAM holds 2^RAM_AW 32-bit words.
- `clk  in  1`: single clock; all state changes on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `if_req  in  1`: fetch request; held until `if_ready`.
- `if_addr  in  32`: fetch byte address.
- `if_ready  out  1`: fetch complete this cycle.
- `if_instr  out  32`: fetched word, valid when `if_ready`, else 0.
- `regmem_M  in  1`: MEM-stage load request.
- `memw_M  in  1`: MEM-stage store request.
- `address_M  in  32`: MEM-stage byte address.
- `wdata_M  in  32`: store data.
- `m_ready  out  1`: data access complete this cycle.
- `m_rdata  out  32`: load data, valid when `m_ready`, else 0.
- `stall_F  out  1`: `if_req & ~if_ready`; holds PC and IF/ID.
- `stall_M  out  1`: `(regmem_M|memw_M) & ~m_ready`; holds EX/MEM and all upstream registers.
- `err_addr  out  1`: sticky flag for a misaligned or out-of-range access.
- `ram_address  out  RAM_AW`: RAM word address.
- `ram_data  out  32`: RAM write data.
- `ram_wren  out  1`: RAM write enable.
- `ram_q  in  32`: RAM read data. The RAM registers address/data/wren on `clk`; `q` is valid in the cycle after the address edge.

## Operation
- Data request `dreq = regmem_M | memw_M`. If `regmem_M` and `memw_M` are both high, the access is a store.
- Word index is `addr[RAM_AW+1:2]`.
- `err_addr` is set on issue if `addr[1:0]!=0` or `addr[31:RAM_AW+2]!=0`. The access still proceeds with the truncated index.
- FSM states: `IDLE`, `D_RESP`, `F_RESP`. Reset state is `IDLE`.
- Issue means driving the RAM port combinationally in the current cycle; the RAM captures it at the next edge.
- `IDLE`:
  - if `dreq`, issue data and go to `D_RESP`;
  - else if `if_req`, issue fetch and go to `F_RESP`;
  - else stay.
- `D_RESP`:
  - `m_ready=1`; `m_rdata=ram_q` for a load, 0 for a store.
  - If `if_req`, issue fetch and go to `F_RESP`; else go to `IDLE`.
  - Data is never re-issued from `D_RESP`.
- `F_RESP`:
  - `if_ready=1`, `if_instr=ram_q`.
  - If `dreq`, issue data and go to `D_RESP`; else go to `IDLE`.
  - Fetch is never re-issued from `F_RESP`.
- The access type (load/store) is latched at issue so `D_RESP` knows whether to return data.
- Requesters must keep address/data/type stable until their ready is high. The request retires at the edge ending the ready cycle.
- When no issue occurs, `ram_wren=0`. `ram_address` and `ram_data` are then don't-care but driven to 0.

## Timing
- Every access is issued in cycle N and ready in cycle N+1, so latency is 2 cycles including the issue cycle.
- Stores write at the edge ending cycle N; `m_ready` is high in N+1.
- Back-to-back alternating accesses achieve one access per cycle. A single requester alone gets at most one access per 2 cycles.
- Simultaneous `dreq` and `if_req` in `IDLE`: data is issued first and fetch is issued in the following cycle.
- Reset values: state `IDLE`, `if_ready=0`, `m_ready=0`, `if_instr=0`, `m_rdata=0`, `ram_wren=0`, `ram_address=0`, `ram_data=0`, `err_addr=0`.
- While `rst` is high, no issue occurs and `ram_wren` is forced to 0.
- Reset asserted mid-operation in either `RESP` state: the ready output in that cycle is suppressed, the FSM is in `IDLE` next cycle, and no pending access is issued.
- `err_addr` clears only on `rst`.

## Structure
- Package `memport_pkg`:
  - state enum `memport_state_t` (`IDLE`, `D_RESP`, `F_RESP`);
  - default `RAM_AW`;
  - the function computing word index and error bit.
- Sub-module `memport_addr_chk` (combinational): produces the word index and error flag from a byte address. It is instantiated once, on the muxed issue address.
- Top level holds the FSM, the latched access type, the `err_addr` register and the output muxes.

## Test plan
- Reset: `rst` held 2 cycles with `if_req=1` and `memw_M=1` → `ram_wren=0`, both readies 0, `err_addr=0`; first issue occurs in the cycle after `rst` falls.
- Lone fetch: `if_addr=0x00000010`, RAM[4]=0xE3A01005 → `ram_address=4` in cycle 0; `if_ready=1` and `if_instr=0xE3A01005` in cycle 1; `stall_F` is 1 then 0.
- Store then load: `memw_M=1`, `address_M=0x00000020`, `wdata_M=0x0000FFFF` → `ram_wren=1`, address 8 in cycle 0, `m_ready` in cycle 1. Then `regmem_M=1` at the same address → `m_rdata=0x0000FFFF` in cycle 3.
- Contention: `if_req` and `regmem_M` both high from cycle 0 → data issued in cycle 0; `m_ready` plus fetch issue in cycle 1; `if_ready` in cycle 2; `stall_F` high in cycles 0–1; `stall_M` high in cycle 0 only.
- Bad address: load at `0x00010006` → `err_addr=1` from cycle 1 onward; access uses word index `0x001` (`addr[11:2]`) and completes normally; `err_addr` cleared only by `rst`. Also check that `regmem_M=memw_M=1` performs a store.
- Reset mid-op: `rst` asserted during `D_RESP` of a load with `if_req` pending → `m_ready=0` in that cycle, `IDLE` next cycle, no fetch issued, `ram_wren` stays 0.
